// File: rtl/irq_latch.sv
// irq_latch: captures 10 interrupt lines into sticky pending bits and runs the
// ack/eoi handshake with the downstream priority encoder. Define IRQ_SYNC_EN for a 2-flop input synchroniser.
module irq_latch (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] irq_in,
    input  logic [9:0] mask,
    input  logic       ack,
    input  logic [3:0] ack_id,
    input  logic       eoi,
    output logic [9:0] req,
    output logic       irq,
    output logic [3:0] cur_id,
    output logic [9:0] ovf
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [3:0] NO_ID  = 4'hF;
    localparam logic [3:0] MAX_ID = 4'd9;

    // Selects vec[id] without ever indexing out of range for ids 10..15.
    function automatic logic bit_at(input logic [9:0] vec, input logic [3:0] id);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (id == 4'(i)) begin
                hit = vec[i];
            end
        end
        return hit;
    endfunction

    // One-hot decode of a channel id; ids above 9 decode to all zeros.
    function automatic logic [9:0] onehot(input logic [3:0] id);
        logic [9:0] oh;
        oh = 10'b0;
        for (int i = 0; i < 10; i++) begin
            if (id == 4'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    logic [9:0] sync_s;
    logic [9:0] prv_r;
    logic [9:0] pending_r;
    logic [9:0] pending_n;
    logic [9:0] ovf_r;
    logic [9:0] ovf_n;
    logic [9:0] req_s;
    logic [9:0] edge_s;
    logic [9:0] ack_mask_s;
    logic       valid_ack_s;
    state_t     state_r;
    state_t     state_n;
    logic       irq_r;
    logic [3:0] cur_id_r;
    logic [3:0] cur_id_n;

`ifdef IRQ_SYNC_EN
    logic [9:0] meta_r;
    logic [9:0] sync_r;

    // Two-flop synchroniser for lines asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 10'b0;
            sync_r <= 10'b0;
        end else begin
            meta_r <= irq_in;
            sync_r <= meta_r;
        end
    end

    assign sync_s = sync_r;
`else
    assign sync_s = irq_in;
`endif

    assign edge_s = sync_s & ~prv_r;

    // Encoder request vector; hidden entirely while a channel is in service.
    always_comb begin
        req_s = 10'b0;
        if (state_r == ST_SERVICE) begin
            req_s = 10'b0;
        end else begin
            req_s = pending_r & ~mask;
        end
    end

    // An ack only counts in ASSERT and only for a channel currently requesting.
    always_comb begin
        valid_ack_s = 1'b0;
        ack_mask_s  = 10'b0;
        if ((state_r == ST_ASSERT) && ack && (ack_id <= MAX_ID) && bit_at(req_s, ack_id)) begin
            valid_ack_s = 1'b1;
            ack_mask_s  = onehot(ack_id);
        end else begin
            valid_ack_s = 1'b0;
            ack_mask_s  = 10'b0;
        end
    end

    // Set beats ack-clear for pending; ack-clear beats set for overflow.
    always_comb begin
        pending_n = (pending_r & ~ack_mask_s) | edge_s;
        ovf_n     = (ovf_r | (edge_s & pending_r)) & ~ack_mask_s;
    end

    // Handshake FSM next-state and next cur_id.
    always_comb begin
        state_n  = state_r;
        cur_id_n = cur_id_r;
        case (state_r)
            ST_IDLE: begin
                if (|req_s) begin
                    state_n = ST_ASSERT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (valid_ack_s) begin
                    state_n  = ST_SERVICE;
                    cur_id_n = ack_id;
                end else if (~|req_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_ASSERT;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_n  = ST_IDLE;
                    cur_id_n = NO_ID;
                end else begin
                    state_n = ST_SERVICE;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                cur_id_n = NO_ID;
            end
        endcase
    end

    // Capture, overflow and handshake state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prv_r     <= 10'b0;
            pending_r <= 10'b0;
            ovf_r     <= 10'b0;
            state_r   <= ST_IDLE;
            irq_r     <= 1'b0;
            cur_id_r  <= NO_ID;
        end else begin
            prv_r     <= sync_s;
            pending_r <= pending_n;
            ovf_r     <= ovf_n;
            state_r   <= state_n;
            irq_r     <= (state_n == ST_ASSERT);
            cur_id_r  <= cur_id_n;
        end
    end

    assign req    = req_s;
    assign irq    = irq_r;
    assign cur_id = cur_id_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_irq_latch.sv
// Self-checking bench for irq_latch: vector table with settle time plus
// hand-written cycle-exact sequences, all checked through an expectation queue.
module tb_irq_latch;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int SETTLE = LAT + 2;

    logic       clk;
    logic       rst_n;
    logic [9:0] irq_in;
    logic [9:0] mask;
    logic       ack;
    logic [3:0] ack_id;
    logic       eoi;
    logic [9:0] req;
    logic       irq;
    logic [3:0] cur_id;
    logic [9:0] ovf;

    typedef struct {
        logic [9:0] req;
        logic       irq;
        logic [3:0] cur;
        logic [9:0] ovf;
    } exp_t;

    typedef struct {
        logic [9:0] irq_in;
        logic [9:0] mask;
        logic       ack;
        logic [3:0] ack_id;
        logic       eoi;
        logic [9:0] e_req;
        logic       e_irq;
        logic [3:0] e_cur;
        logic [9:0] e_ovf;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[18];
    int   n_vec  = 0;
    int   n_miss = 0;

    irq_latch dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_in (irq_in),
        .mask   (mask),
        .ack    (ack),
        .ack_id (ack_id),
        .eoi    (eoi),
        .req    (req),
        .irq    (irq),
        .cur_id (cur_id),
        .ovf    (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [9:0] r, input logic i, input logic [3:0] c, input logic [9:0] o);
        exp_t e;
        e.req = r;
        e.irq = i;
        e.cur = c;
        e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL %s: no expectation queued", name);
        end else begin
            e = sb.pop_front();
            n_vec++;
            if (req !== e.req || irq !== e.irq || cur_id !== e.cur || ovf !== e.ovf) begin
                n_miss++;
                $display("FAIL %s: got req=%h irq=%b cur_id=%h ovf=%h, expected req=%h irq=%b cur_id=%h ovf=%h",
                         name, req, irq, cur_id, ovf, e.req, e.irq, e.cur, e.ovf);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{10'h008, 10'h000, 1'b0, 4'd0,  1'b0, 10'h000, 1'b0, 4'hF, 10'h000};
        vecs[1]  = '{10'h029, 10'h001, 1'b0, 4'd0,  1'b0, 10'h020, 1'b1, 4'hF, 10'h000};
        vecs[2]  = '{10'h029, 10'h001, 1'b1, 4'd0,  1'b0, 10'h020, 1'b1, 4'hF, 10'h000};
        vecs[3]  = '{10'h029, 10'h001, 1'b1, 4'd12, 1'b0, 10'h020, 1'b1, 4'hF, 10'h000};
        vecs[4]  = '{10'h029, 10'h000, 1'b0, 4'd0,  1'b0, 10'h021, 1'b1, 4'hF, 10'h000};
        vecs[5]  = '{10'h029, 10'h000, 1'b1, 4'd5,  1'b0, 10'h000, 1'b0, 4'd5, 10'h000};
        vecs[6]  = '{10'h029, 10'h000, 1'b1, 4'd0,  1'b0, 10'h000, 1'b0, 4'd5, 10'h000};
        vecs[7]  = '{10'h029, 10'h000, 1'b0, 4'd0,  1'b1, 10'h001, 1'b1, 4'hF, 10'h000};
        vecs[8]  = '{10'h029, 10'h000, 1'b1, 4'd0,  1'b0, 10'h000, 1'b0, 4'd0, 10'h000};
        vecs[9]  = '{10'h029, 10'h000, 1'b0, 4'd0,  1'b1, 10'h000, 1'b0, 4'hF, 10'h000};
        vecs[10] = '{10'h029, 10'h000, 1'b0, 4'd0,  1'b1, 10'h000, 1'b0, 4'hF, 10'h000};
        vecs[11] = '{10'h208, 10'h000, 1'b0, 4'd0,  1'b0, 10'h200, 1'b1, 4'hF, 10'h000};
        vecs[12] = '{10'h008, 10'h000, 1'b0, 4'd0,  1'b0, 10'h200, 1'b1, 4'hF, 10'h000};
        vecs[13] = '{10'h208, 10'h000, 1'b0, 4'd0,  1'b0, 10'h200, 1'b1, 4'hF, 10'h200};
        vecs[14] = '{10'h208, 10'h200, 1'b0, 4'd0,  1'b0, 10'h000, 1'b0, 4'hF, 10'h200};
        vecs[15] = '{10'h208, 10'h000, 1'b0, 4'd0,  1'b0, 10'h200, 1'b1, 4'hF, 10'h200};
        vecs[16] = '{10'h208, 10'h000, 1'b1, 4'd9,  1'b0, 10'h000, 1'b0, 4'd9, 10'h000};
        vecs[17] = '{10'h208, 10'h000, 1'b0, 4'd0,  1'b1, 10'h000, 1'b0, 4'hF, 10'h000};

        rst_n  = 1'b0;
        irq_in = 10'h000;
        mask   = 10'h000;
        ack    = 1'b0;
        ack_id = 4'd0;
        eoi    = 1'b0;

        // Reset held while lines toggle.
        irq_in = 10'h3FF;
        expect_out(10'h000, 1'b0, 4'hF, 10'h000);
        step();
        check("rst_hold_a");
        irq_in = 10'h155;
        expect_out(10'h000, 1'b0, 4'hF, 10'h000);
        step();
        step();
        check("rst_hold_b");
        irq_in = 10'h000;
        step();
        rst_n = 1'b1;
        expect_out(10'h000, 1'b0, 4'hF, 10'h000);
        repeat (LAT + 3) step();
        check("rst_release_idle");

        // Single request on channel 3 with exact latency.
        irq_in = 10'h008;
        expect_out(10'h008, 1'b0, 4'hF, 10'h000);
        repeat (LAT + 1) step();
        check("single_req_latency");
        expect_out(10'h008, 1'b1, 4'hF, 10'h000);
        step();
        check("single_irq_latency");
        ack    = 1'b1;
        ack_id = 4'd3;
        expect_out(10'h000, 1'b0, 4'd3, 10'h000);
        step();
        ack = 1'b0;
        check("single_ack");
        eoi = 1'b1;
        expect_out(10'h000, 1'b0, 4'hF, 10'h000);
        step();
        eoi = 1'b0;
        check("single_eoi");
        expect_out(10'h000, 1'b0, 4'hF, 10'h000);
        step();
        check("single_stay_idle");

        for (int v = 0; v < 18; v++) begin
            irq_in = vecs[v].irq_in;
            mask   = vecs[v].mask;
            ack    = vecs[v].ack;
            ack_id = vecs[v].ack_id;
            eoi    = vecs[v].eoi;
            expect_out(vecs[v].e_req, vecs[v].e_irq, vecs[v].e_cur, vecs[v].e_ovf);
            step();
            ack = 1'b0;
            eoi = 1'b0;
            repeat (SETTLE) step();
            check($sformatf("vec%0d", v));
        end

        // Collision: new edge on channel 2 lands on the same edge as its ack.
        irq_in = 10'h20C;
        expect_out(10'h004, 1'b1, 4'hF, 10'h000);
        repeat (SETTLE + 1) step();
        check("col_setup");
        irq_in = 10'h208;
        expect_out(10'h004, 1'b1, 4'hF, 10'h000);
        repeat (SETTLE + 1) step();
        check("col_line_low");
        irq_in = 10'h20C;
        repeat (LAT) step();
        ack    = 1'b1;
        ack_id = 4'd2;
        expect_out(10'h000, 1'b0, 4'd2, 10'h000);
        step();
        ack = 1'b0;
        check("col_ack");
        eoi = 1'b1;
        expect_out(10'h004, 1'b0, 4'hF, 10'h000);
        step();
        eoi = 1'b0;
        check("col_eoi_idle");
        expect_out(10'h004, 1'b1, 4'hF, 10'h000);
        step();
        check("col_reassert");

        // Reset in the middle of servicing channel 7.
        ack    = 1'b1;
        ack_id = 4'd2;
        step();
        ack = 1'b0;
        eoi = 1'b1;
        step();
        eoi    = 1'b0;
        irq_in = 10'h28C;
        expect_out(10'h080, 1'b1, 4'hF, 10'h000);
        repeat (SETTLE + 1) step();
        check("mid_setup");
        ack    = 1'b1;
        ack_id = 4'd7;
        expect_out(10'h000, 1'b0, 4'd7, 10'h000);
        step();
        ack = 1'b0;
        check("mid_service");
        #2;
        rst_n = 1'b0;
        #1;
        expect_out(10'h000, 1'b0, 4'hF, 10'h000);
        check("mid_async_reset");
        step();
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
